uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// - UART transmit path directly downstream of the UART register block.
// - Accepts bytes from the TXDATA write strobe into a TX FIFO, then serialises them on the tx pin at divider-derived baud.
// - Returns TX status and IRQ flags to the register block and drives the TX interrupt line.
// PARAMETERS
// - FIFO_DEPTH  16  TX FIFO entries; power of 2, 2..256
// PORTS
// - clk              in   1   system clock
// - rst_n            in   1   asynchronous active-low reset
// - uart_divider     in   32  clk cycles per bit; values < 2 halt bit timing
// - uart_txdata      in   8   byte to queue
// - uart_txdata_valid in  1   1-cycle push strobe
// - uart_config      in   Config_t  [0] tx_en, [2] parity_en, [3] parity_odd, [4] stop2; other bits ignored
// - uart_txirqmask   in   32  bits [4:0] enable TXIrqFlags_t bits
// - tx_ovf_clr       in   1   clears sticky overflow flag
// - uart_txstatus    out  32  [8:0] FIFO level, [16] busy, [17] full, [18] empty, rest 0
// - uart_txirqflags  out  TXIrqFlags_t  {done, overflow, full, half, empty}
// - tx_irq           out  1   |(flags & mask[4:0])
// - tx               out  1   serial line, idle high
// - cts_n            in   1   only with UART_TX_CTS_EN; active-low clear-to-send
// BEHAVIOUR
// - Reset values: tx=1, FIFO empty, uart_txstatus={13'h0,1'b1,1'b0,1'b0,16'h0}, flags={0,0,0,0,1}, tx_irq=mask[0]&1 (combinational).
// - Reset is asynchronous mid-frame: tx returns high immediately and the FIFO is flushed.
// - Push: on txdata_valid, write the byte when not full.
//   - If full, drop the byte and set overflow (sticky) until tx_ovf_clr.
//   - If a set and a clear coincide, set wins.
// - Simultaneous push and pop: level unchanged; legal when full (pop frees the slot in the same cycle) and when empty (no bypass, byte goes through FIFO).
// - Baud counter: loads divider-1 at frame start and on each tick; decrements; tick when 0.
//   - divider < 2: no ticks, the FSM freezes in its current state, tx holds its value.
// - FSM states and transitions:
//   - IDLE -> START when tx_en && !empty; pop the byte, latch parity_en/parity_odd/stop2 for the whole frame.
//   - START: tx=0 for one bit.
//   - DATA: 8 bits, LSB first; 3-bit bit counter.
//   - PARITY: only if parity_en; even = ^data, odd = ~^data.
//   - STOP: tx=1 for 1 or 2 bits -> IDLE.
//   - One bit = divider clk cycles.
// - Latency: tx falls 1 cycle after FIFO non-empty in IDLE. Back-to-back frames have no extra idle bit.
// - tx_en cleared mid-frame: the frame completes, then the FSM stays in IDLE; FIFO contents are retained.
// - Config and divider changes mid-frame:
//   - Frame format is latched at frame start; config changes take effect on the next frame.
//   - Divider is taken at each counter reload.
// - Status: busy = state != IDLE.
// - Flags: empty = level==0; half = level >= FIFO_DEPTH/2; full = level==FIFO_DEPTH.
// - done: 1-cycle pulse in the last cycle of the final STOP bit when the FIFO is empty.
// - Level width: $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
// - UART_TX_CTS_EN defined:
//   - Add port cts_n, synchronised through 2 flops.
//   - IDLE->START additionally requires synced cts_n==0.
//   - cts_n deassertion mid-frame does not abort the frame.
// - UART_TX_CTS_EN undefined: no cts_n port; start depends only on tx_en and FIFO state.
// STRUCTURE
// - uart_defs holds Config_t, TXIrqFlags_t, TX status bit position constants, and the TxState_t enum (IDLE, START, DATA, PARITY, STOP).
// - Sub-module uart_tx_fifo (parameter FIFO_DEPTH, 8-bit): push/pop/full/empty/level; registered storage, combinational read of head.
// - uart_tx holds the baud counter, FSM, shift register, and flag/IRQ logic.
// TESTING
// - divider=4, tx_en=1, push 8'hA5 -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1, then 4 cycles high; done pulse; level back to 0.
// - parity_en=1, parity_odd=0, stop2=1, push 8'h07 -> parity bit 1, 8 stop cycles high; parity_odd=1 gives parity bit 0.
// - FIFO_DEPTH=16, tx_en=0, push 17 bytes:
//   - level=16, full=1, half=1, overflow=1;
//   - tx_ovf_clr clears overflow;
//   - set tx_en=1 -> 16 frames back-to-back with no gap.
// - Push and pop in the same cycle with level=16 -> level stays 16, no overflow.
// - Assert rst_n low during DATA -> tx=1 at once, status empty; after release no residual frame.
// - UART_TX_CTS_EN, cts_n=1, one byte queued -> tx stays 1; cts_n=0 -> start bit 3 cycles later (sync + start).

Source files
------------

// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared types and constants for the UART transmit path
package uart_defs;

  // Register-block configuration word; only the transmit-related bits are consumed.
  typedef struct packed {
    logic [26:0] reserved_hi;
    logic        stop2;
    logic        parity_odd;
    logic        parity_en;
    logic        reserved_1;
    logic        tx_en;
  } Config_t;

  // Interrupt flags as seen by the register block; bit 0 is empty, bit 4 is done.
  typedef struct packed {
    logic done;
    logic overflow;
    logic full;
    logic half;
    logic empty;
  } TXIrqFlags_t;

  // Bit positions inside the 32-bit TX status word.
  localparam int TXSTATUS_LEVEL_LSB = 0;
  localparam int TXSTATUS_LEVEL_W   = 9;
  localparam int TXSTATUS_BUSY      = 16;
  localparam int TXSTATUS_FULL      = 17;
  localparam int TXSTATUS_EMPTY     = 18;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } TxState_t;

  // Parity bit for a byte: even parity makes the total count of ones even.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO between the TXDATA strobe and the serialiser
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] count;

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == LW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: TX FIFO, baud counter, framing FSM, status and IRQ (optional UART_TX_CTS_EN flow control)
module uart_tx
  import uart_defs::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] uart_divider,
  input  logic [7:0]  uart_txdata,
  input  logic        uart_txdata_valid,
  input  Config_t     uart_config,
  input  logic [31:0] uart_txirqmask,
  input  logic        tx_ovf_clr,
  output logic [31:0] uart_txstatus,
  output TXIrqFlags_t uart_txirqflags,
  output logic        tx_irq,
  output logic        tx
`ifdef UART_TX_CTS_EN
  ,
  input  logic        cts_n
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;

  TxState_t      state;
  logic [31:0]   baud_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          stop_second;
  logic          par_en_q;
  logic          par_bit_q;
  logic          stop2_q;
  logic          ovf;

  logic          div_ok;
  logic          baud_tick;
  logic          cts_ok;
  logic          can_start;
  logic          last_stop;
  logic          start_frame;
  logic          ovf_set;
  logic [31:0]   reload;
  logic          unused_inputs;

  assign unused_inputs = ^{uart_config.reserved_hi, uart_config.reserved_1, uart_txirqmask[31:5]};

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (uart_txdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Two-flop synchroniser for the asynchronous clear-to-send input; idles as "not clear".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_sync <= 2'b11;
    end else begin
      cts_sync <= {cts_sync[0], cts_n};
    end
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  // A divider below 2 freezes bit timing entirely, including frame starts.
  assign div_ok    = (uart_divider >= 32'd2);
  assign reload    = uart_divider - 32'd1;
  assign baud_tick = div_ok && (state != IDLE) && (baud_cnt == 32'd0);
  assign can_start = uart_config.tx_en && !fifo_empty && cts_ok;
  assign last_stop = (state == STOP) && baud_tick && (!stop2_q || stop_second);

  // A new frame may start from IDLE or straight out of the final stop bit, so
  // back-to-back bytes leave no idle gap on the line.
  assign start_frame = div_ok && can_start && ((state == IDLE) || last_stop);

  // A pop in the same cycle frees the slot, so a push to a full FIFO is then accepted.
  assign fifo_pop  = start_frame;
  assign fifo_push = uart_txdata_valid && (!fifo_full || fifo_pop);
  assign ovf_set   = uart_txdata_valid && fifo_full && !fifo_pop;

  // Framing FSM with baud counter and shift register; tx is a registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx          <= 1'b1;
      baud_cnt    <= 32'd0;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      stop_second <= 1'b0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
    end else if (start_frame) begin
      state       <= START;
      tx          <= 1'b0;
      baud_cnt    <= reload;
      shreg       <= fifo_head;
      bit_cnt     <= 3'd0;
      stop_second <= 1'b0;
      par_en_q    <= uart_config.parity_en;
      par_bit_q   <= parity_bit(fifo_head, uart_config.parity_odd);
      stop2_q     <= uart_config.stop2;
    end else if (baud_tick) begin
      baud_cnt <= reload;
      case (state)
        START: begin
          state   <= DATA;
          tx      <= shreg[0];
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= 3'd0;
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            if (par_en_q) begin
              state <= PARITY;
              tx    <= par_bit_q;
            end else begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end else begin
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: begin
          if (stop2_q && !stop_second) begin
            stop_second <= 1'b1;
          end else begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end else if (div_ok && (state != IDLE)) begin
      baud_cnt <= baud_cnt - 32'd1;
    end
  end

  // Sticky overflow; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= (ovf && !tx_ovf_clr) || ovf_set;
    end
  end

  // Status word and IRQ flags derived from FIFO level and FSM state.
  always_comb begin
    uart_txstatus = 32'h0;
    uart_txstatus[TXSTATUS_LEVEL_LSB +: TXSTATUS_LEVEL_W] = TXSTATUS_LEVEL_W'(fifo_level);
    uart_txstatus[TXSTATUS_BUSY]  = (state != IDLE);
    uart_txstatus[TXSTATUS_FULL]  = fifo_full;
    uart_txstatus[TXSTATUS_EMPTY] = fifo_empty;

    uart_txirqflags          = '0;
    uart_txirqflags.empty    = fifo_empty;
    uart_txirqflags.half     = (fifo_level >= LW'(FIFO_DEPTH / 2));
    uart_txirqflags.full     = fifo_full;
    uart_txirqflags.overflow = ovf;
    uart_txirqflags.done     = last_stop && fifo_empty;
  end

  assign tx_irq = |(uart_txirqflags & uart_txirqmask[4:0]);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-level reference model
module tb_uart_tx;
  import uart_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] uart_divider = 32'd4;
  logic [7:0]  uart_txdata = 8'h00;
  logic        uart_txdata_valid = 1'b0;
  Config_t     cfg = '0;
  logic [31:0] uart_txirqmask = 32'h0;
  logic        tx_ovf_clr = 1'b0;
  logic [31:0] uart_txstatus;
  TXIrqFlags_t uart_txirqflags;
  logic        tx_irq;
  logic        tx;
`ifdef UART_TX_CTS_EN
  logic        cts_n = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int div = 4;

  bit         exp_cyc[$];
  logic       obs_tx[$];
  logic       obs_done[$];
  logic [7:0] pend[$];

  uart_tx #(.FIFO_DEPTH(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart_divider      (uart_divider),
    .uart_txdata       (uart_txdata),
    .uart_txdata_valid (uart_txdata_valid),
    .uart_config       (cfg),
    .uart_txirqmask    (uart_txirqmask),
    .tx_ovf_clr        (tx_ovf_clr),
    .uart_txstatus     (uart_txstatus),
    .uart_txirqflags   (uart_txirqflags),
    .tx_irq            (tx_irq),
    .tx                (tx)
`ifdef UART_TX_CTS_EN
    ,
    .cts_n             (cts_n)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a frame is start 0, data LSB first, optional parity, 1 or 2 stop 1s; each bit lasts div cycles.
  function automatic void model_frame(input logic [7:0] d, input bit pen, input bit podd, input bit s2);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((($countones(d) + int'(podd)) % 2) == 1);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) repeat (div) exp_cyc.push_back(bits[i]);
  endfunction

  task automatic capture(input int n);
    obs_tx.delete();
    obs_done.delete();
    repeat (n) begin
      @(negedge clk);
      obs_tx.push_back(tx);
      obs_done.push_back(uart_txirqflags.done);
    end
  endtask

  function automatic int first_diff();
    foreach (obs_tx[i]) if (obs_tx[i] !== exp_cyc[i]) return i;
    return -1;
  endfunction

  function automatic int done_count();
    int n = 0;
    foreach (obs_done[i]) if (obs_done[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic push_pending();
    @(posedge clk);
    #1;
    uart_txdata_valid = 1'b1;
    while (pend.size() > 0) begin
      uart_txdata = pend.pop_front();
      @(posedge clk);
      #1;
    end
    uart_txdata_valid = 1'b0;
  endtask

  task automatic test_reset();
    uart_txirqmask = 32'h1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (uart_txstatus !== 32'h0004_0000) begin errors++; $display("FAIL reset_status: got %h want 00040000", uart_txstatus); end
    checks++;
    if (uart_txirqflags !== 5'b00001) begin errors++; $display("FAIL reset_flags: got %b want 00001", uart_txirqflags); end
    checks++;
    if (tx_irq !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b want 1", tx_irq); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    uart_txirqmask = 32'h0;
  endtask

  task automatic test_basic_frame();
    int idx;
    div = 4;
    uart_divider = 32'd4;
    cfg.tx_en = 1'b1;
    exp_cyc.delete();
    exp_cyc.push_back(1'b1);
    model_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    exp_cyc.push_back(1'b1);
    pend.push_back(8'hA5);
    push_pending();
    capture(exp_cyc.size());
    idx = first_diff();
    checks++;
    if (idx >= 0) begin errors++; $display("FAIL frame_a5: cycle %0d tx=%b want %b", idx, obs_tx[idx], exp_cyc[idx]); end
    checks++;
    if (done_count() !== 1 || obs_done[40] !== 1'b1) begin
      errors++; $display("FAIL done_a5: pulses=%0d at_last=%b want 1 and 1", done_count(), obs_done[40]);
    end
    checks++;
    if (uart_txstatus !== 32'h0004_0000) begin errors++; $display("FAIL idle_after_a5: status %h want 00040000", uart_txstatus); end
  endtask

  task automatic test_parity();
    int idx;
    logic [7:0] d;
    bit pen, podd, s2;
    for (int k = 0; k < 6; k++) begin
      if (k < 2) begin
        d = 8'h07; pen = 1'b1; podd = (k == 1); s2 = 1'b1; div = 4;
      end else begin
        d = 8'($urandom); pen = 1'($urandom); podd = 1'($urandom); s2 = 1'($urandom);
        div = $urandom_range(2, 6);
      end
      uart_divider = 32'(div);
      cfg.parity_en = pen;
      cfg.parity_odd = podd;
      cfg.stop2 = s2;
      exp_cyc.delete();
      exp_cyc.push_back(1'b1);
      model_frame(d, pen, podd, s2);
      pend.push_back(d);
      push_pending();
      capture(exp_cyc.size());
      idx = first_diff();
      checks++;
      if (idx >= 0) begin
        errors++; $display("FAIL parity_frame%0d d=%h: cycle %0d tx=%b want %b", k, d, idx, obs_tx[idx], exp_cyc[idx]);
      end
      checks++;
      if (done_count() !== 1 || obs_done[obs_done.size()-1] !== 1'b1) begin
        errors++; $display("FAIL parity_done%0d: pulses=%0d want 1 at last cycle", k, done_count());
      end
      @(negedge clk);
    end
    cfg.parity_en = 1'b0;
    cfg.parity_odd = 1'b0;
    cfg.stop2 = 1'b0;
    div = 4;
    uart_divider = 32'd4;
  endtask

  task automatic test_txen_midframe();
    int idx;
    logic [7:0] b0, b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    cfg.tx_en = 1'b1;
    pend.push_back(b0);
    pend.push_back(b1);
    push_pending();
    cfg.tx_en = 1'b0;
    exp_cyc.delete();
    model_frame(b0, 1'b0, 1'b0, 1'b0);
    repeat (12) exp_cyc.push_back(1'b1);
    capture(exp_cyc.size());
    idx = first_diff();
    checks++;
    if (idx >= 0) begin errors++; $display("FAIL txen_off_frame: cycle %0d tx=%b want %b", idx, obs_tx[idx], exp_cyc[idx]); end
    checks++;
    if (done_count() !== 0) begin errors++; $display("FAIL txen_off_done: pulses=%0d want 0", done_count()); end
    checks++;
    if (uart_txstatus !== 32'h0000_0001) begin errors++; $display("FAIL txen_off_retained: status %h want 00000001", uart_txstatus); end
    @(posedge clk);
    #1;
    cfg.tx_en = 1'b1;
    exp_cyc.delete();
    exp_cyc.push_back(1'b1);
    model_frame(b1, 1'b0, 1'b0, 1'b0);
    capture(exp_cyc.size());
    idx = first_diff();
    checks++;
    if (idx >= 0) begin errors++; $display("FAIL txen_on_frame: cycle %0d tx=%b want %b", idx, obs_tx[idx], exp_cyc[idx]); end
    @(negedge clk);
  endtask

  task automatic test_divider_halt();
    int bad, idx;
    logic [7:0] d;
    d = 8'($urandom);
    uart_divider = 32'd1;
    cfg.tx_en = 1'b1;
    pend.push_back(d);
    push_pending();
    capture(20);
    bad = 0;
    foreach (obs_tx[i]) if (obs_tx[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_tx: %0d low cycles want 0", bad); end
    checks++;
    if (uart_txstatus !== 32'h0000_0001) begin errors++; $display("FAIL halt_status: %h want 00000001", uart_txstatus); end
    @(posedge clk);
    #1;
    div = 4;
    uart_divider = 32'd4;
    exp_cyc.delete();
    exp_cyc.push_back(1'b1);
    model_frame(d, 1'b0, 1'b0, 1'b0);
    capture(exp_cyc.size());
    idx = first_diff();
    checks++;
    if (idx >= 0) begin errors++; $display("FAIL halt_resume: cycle %0d tx=%b want %b", idx, obs_tx[idx], exp_cyc[idx]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int idx;
    logic [7:0] bytes[17];
    logic [7:0] extra;
    cfg.tx_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bytes[i] = 8'($urandom);
      pend.push_back(bytes[i]);
    end
    push_pending();
    uart_txirqmask = 32'h4;
    @(negedge clk);
    checks++;
    if (uart_txstatus !== 32'h0002_0010) begin errors++; $display("FAIL full_status: %h want 00020010", uart_txstatus); end
    checks++;
    if (uart_txirqflags !== 5'b01110) begin errors++; $display("FAIL full_flags: %b want 01110", uart_txirqflags); end
    checks++;
    if (tx_irq !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL full_irq_tx: irq=%b tx=%b want 1 1", tx_irq, tx); end
    uart_txirqmask = 32'h0;
    @(posedge clk); #1; tx_ovf_clr = 1'b1;
    @(posedge clk); #1; tx_ovf_clr = 1'b0;
    checks++;
    if (uart_txirqflags.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: %b want 0", uart_txirqflags.overflow); end
    tx_ovf_clr = 1'b1;
    uart_txdata_valid = 1'b1;
    @(posedge clk); #1;
    tx_ovf_clr = 1'b0;
    uart_txdata_valid = 1'b0;
    checks++;
    if (uart_txirqflags.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: %b want 1", uart_txirqflags.overflow); end
    tx_ovf_clr = 1'b1;
    @(posedge clk); #1;
    tx_ovf_clr = 1'b0;
    extra = 8'($urandom);
    cfg.tx_en = 1'b1;
    uart_txdata = extra;
    uart_txdata_valid = 1'b1;
    @(posedge clk); #1;
    uart_txdata_valid = 1'b0;
    checks++;
    if (uart_txstatus[8:0] !== 9'd16 || uart_txirqflags.overflow !== 1'b0) begin
      errors++; $display("FAIL push_pop_full: level=%0d ovf=%b want 16 0", uart_txstatus[8:0], uart_txirqflags.overflow);
    end
    exp_cyc.delete();
    for (int i = 0; i < 16; i++) model_frame(bytes[i], 1'b0, 1'b0, 1'b0);
    model_frame(extra, 1'b0, 1'b0, 1'b0);
    capture(exp_cyc.size());
    idx = first_diff();
    checks++;
    if (idx >= 0) begin errors++; $display("FAIL b2b_stream: cycle %0d tx=%b want %b", idx, obs_tx[idx], exp_cyc[idx]); end
    checks++;
    if (done_count() !== 1 || obs_done[obs_done.size()-1] !== 1'b1) begin
      errors++; $display("FAIL b2b_done: pulses=%0d want 1 at end", done_count());
    end
    @(negedge clk);
    checks++;
    if (uart_txstatus !== 32'h0004_0000) begin errors++; $display("FAIL b2b_drained: %h want 00040000", uart_txstatus); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    cfg.tx_en = 1'b1;
    pend.push_back(8'h00);
    push_pending();
    repeat (8) @(posedge clk);
    #2;
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_data: tx=%b want 0", tx); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || uart_txstatus !== 32'h0004_0000) begin
      errors++; $display("FAIL async_reset: tx=%b status=%h want 1 00040000", tx, uart_txstatus);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    capture(60);
    bad = 0;
    foreach (obs_tx[i]) if (obs_tx[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0 || uart_txstatus !== 32'h0004_0000) begin
      errors++; $display("FAIL post_reset_idle: low=%0d status=%h want 0 00040000", bad, uart_txstatus);
    end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    int bad, idx;
    logic [7:0] d;
    d = 8'($urandom);
    cts_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pend.push_back(d);
    push_pending();
    capture(10);
    bad = 0;
    foreach (obs_tx[i]) if (obs_tx[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL cts_blocked: %0d low cycles want 0", bad); end
    @(posedge clk); #1;
    cts_n = 1'b0;
    exp_cyc.delete();
    repeat (3) exp_cyc.push_back(1'b1);
    model_frame(d, 1'b0, 1'b0, 1'b0);
    capture(exp_cyc.size());
    idx = first_diff();
    checks++;
    if (idx >= 0) begin errors++; $display("FAIL cts_release: cycle %0d tx=%b want %b", idx, obs_tx[idx], exp_cyc[idx]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_txen_midframe();
    test_divider_halt();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
